core_id_inst_queue: RTL and testbench

CORE_ID_INST_QUEUE -- requirements
Module: core_id_inst_queue

---
 rtl/core_id_inst_queue_pkg.sv | 21 ++
 rtl/gnrl_fifo_ptr.sv | 61 ++++++
 rtl/core_id_inst_queue.sv | 61 ++++++
 tb/tb_core_id_inst_queue.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/core_id_inst_queue_pkg.sv
// Shared defaults for the IF->ID instruction queue.
// The core-wide width/depth macros are guarded so a central definition wins if one is already loaded.
`ifndef CORE_DEFINES_V
`define CORE_DEFINES_V
`define CORE_PC_WIDTH   32
`define CORE_INST_WIDTH 32
`define CORE_IQ_DEPTH   4
`endif

package core_id_inst_queue_pkg;

    localparam int CORE_PC_W     = `CORE_PC_WIDTH;
    localparam int CORE_INST_W   = `CORE_INST_WIDTH;
    localparam int IQ_DEPTH_DEF  = `CORE_IQ_DEPTH;

    // Pointer width: index bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : core_id_inst_queue_pkg

// File: rtl/gnrl_fifo_ptr.sv
// Generic FIFO pointer/flag unit with its payload storage.
// Pointers carry a wrap bit, so full and empty are told apart without a separate counter.
module gnrl_fifo_ptr
    import core_id_inst_queue_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 8,
    localparam int PTR_W  = ptr_w(DEPTH),
    localparam int AW     = PTR_W - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push_req,
    input  logic              pop_req,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [PTR_W-1:0]  count
);

    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] mem [DEPTH];

    // Flags derive from registered pointers only, so nothing passes through combinationally.
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    assign count = wptr - rptr;

    // A full queue stalls its input even when a pop frees a slot in the same cycle.
    assign push = push_req && !full && !flush;
    assign pop  = pop_req && !empty && !flush;

    // Pointer update: flush beats any push/pop, and natural overflow toggles the wrap bit.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Payload write at the write index; flush and reset leave the contents alone.
    // NOTE: storage has no reset -- the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];

endmodule : gnrl_fifo_ptr

// File: rtl/core_id_inst_queue.sv
// IF->ID instruction queue: buffers {pc, inst, prediction} entries between fetch and decode.
module core_id_inst_queue
    import core_id_inst_queue_pkg::*;
#(
    parameter int DEPTH  = `CORE_IQ_DEPTH,
    parameter int PC_W   = `CORE_PC_WIDTH,
    parameter int INST_W = `CORE_INST_WIDTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [INST_W-1:0] i_inst,
    input  logic              i_branch_predict,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [PC_W-1:0]   o_pc,
    output logic [INST_W-1:0] o_inst,
    output logic              o_branch_predict,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty
);

    localparam int DATA_W = PC_W + INST_W + 1;
    localparam int PTR_W  = ptr_w(DEPTH);

    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic [PTR_W-1:0]  count;

    // One packed word per entry keeps pc, inst and prediction bit together.
    assign wdata = {i_branch_predict, i_inst, i_pc};

    gnrl_fifo_ptr #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (i_flush),
        .push_req (valid_in),
        .pop_req  (ready_out),
        .wdata    (wdata),
        .rdata    (rdata),
        .full     (o_full),
        .empty    (o_empty),
        .count    (count)
    );

    assign ready_in         = !o_full;
    assign valid_out        = !o_empty;
    assign o_pc             = rdata[PC_W-1:0];
    assign o_inst           = rdata[PC_W +: INST_W];
    assign o_branch_predict = rdata[DATA_W-1];
    assign o_count          = CNT_W'(count);

endmodule : core_id_inst_queue

// File: tb/tb_core_id_inst_queue.sv
// Self-checking bench for core_id_inst_queue: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_core_id_inst_queue;
    import core_id_inst_queue_pkg::*;

    localparam int DEPTH  = 4;
    localparam int PC_W   = CORE_PC_W;
    localparam int INST_W = CORE_INST_W;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              bp;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_flush;
    logic              valid_in;
    logic              ready_in;
    logic [PC_W-1:0]   i_pc;
    logic [INST_W-1:0] i_inst;
    logic              i_branch_predict;
    logic              valid_out;
    logic              ready_out;
    logic [PC_W-1:0]   o_pc;
    logic [INST_W-1:0] o_inst;
    logic              o_branch_predict;
    logic [CNT_W-1:0]  o_count;
    logic              o_full;
    logic              o_empty;

    int n_total = 0;
    int n_pass  = 0;

    entry_t model_q[$];

    core_id_inst_queue #(
        .DEPTH  (DEPTH),
        .PC_W   (PC_W),
        .INST_W (INST_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_flush          (i_flush),
        .valid_in         (valid_in),
        .ready_in         (ready_in),
        .i_pc             (i_pc),
        .i_inst           (i_inst),
        .i_branch_predict (i_branch_predict),
        .valid_out        (valid_out),
        .ready_out        (ready_out),
        .o_pc             (o_pc),
        .o_inst           (o_inst),
        .o_branch_predict (o_branch_predict),
        .o_count          (o_count),
        .o_full           (o_full),
        .o_empty          (o_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Compare every output against the model's view of the queue.
    task automatic check_state(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, ".valid_out"}, 64'(valid_out), 64'(sz != 0));
        check({tag, ".ready_in"},  64'(ready_in),  64'(sz < DEPTH));
        check({tag, ".count"},     64'(o_count),   64'(sz));
        check({tag, ".full"},      64'(o_full),    64'(sz == DEPTH));
        check({tag, ".empty"},     64'(o_empty),   64'(sz == 0));
        if (sz != 0) begin
            check({tag, ".pc"},   64'(o_pc),             64'(model_q[0].pc));
            check({tag, ".inst"}, 64'(o_inst),           64'(model_q[0].inst));
            check({tag, ".bp"},   64'(o_branch_predict), 64'(model_q[0].bp));
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic f, input logic [PC_W-1:0] pc);
        valid_in         = v;
        ready_out        = r;
        i_flush          = f;
        i_pc             = pc;
        i_inst           = INST_W'(~pc);
        i_branch_predict = pc[3];
    endtask

    // One clock: predict from queue occupancy, advance the model at the edge, then check.
    task automatic step(input string tag);
        bit     do_push;
        bit     do_pop;
        entry_t e;
        do_pop  = !i_flush && ready_out && (model_q.size() > 0);
        do_push = !i_flush && valid_in && (model_q.size() < DEPTH);
        e = '{pc: i_pc, inst: i_inst, bp: i_branch_predict};
        @(posedge clk);
        if (i_flush) model_q.delete();
        else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(e);
        end
        @(negedge clk);
        check_state(tag);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst.valid_out", 64'(valid_out), 64'd0);
        check("rst.ready_in",  64'(ready_in),  64'd1);
        check("rst.empty",     64'(o_empty),   64'd1);
        check("rst.full",      64'(o_full),    64'd0);
        check("rst.count",     64'(o_count),   64'd0);

        // Fill: first edge after reset release already accepts a push.
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 1'b0, PC_W'(32'h100 + 4 * i));
            step($sformatf("fill%0d", i));
        end
        check("fill.full",     64'(o_full),   64'd1);
        check("fill.ready_in", 64'(ready_in), 64'd0);
        check("fill.count",    64'(o_count),  64'd4);
        check("fill.pc",       64'(o_pc),     64'h100);

        // Drain in push order.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, 1'b0, '0);
            check($sformatf("drain%0d.pc", i), 64'(o_pc), 64'(32'h100 + 4 * i));
            step($sformatf("drain%0d", i));
        end
        check("drain.empty",     64'(o_empty),   64'd1);
        check("drain.valid_out", 64'(valid_out), 64'd0);

        // Steady push+pop at count 2, crossing the pointer wrap.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, PC_W'(32'h400 + 4 * i));
            step($sformatf("pre%0d", i));
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, PC_W'(32'h408 + 4 * i));
            check($sformatf("wrap%0d.pc", i), 64'(o_pc), 64'(32'h400 + 4 * i));
            step($sformatf("wrap%0d", i));
            check($sformatf("wrap%0d.cnt", i), 64'(o_count), 64'd2);
        end

        // Flush beats a concurrent push and pop; the pushed entry is dropped.
        drive(1'b1, 1'b0, 1'b0, PC_W'(32'h500));
        step("pre_flush");
        check("pre_flush.count", 64'(o_count), 64'd3);
        drive(1'b1, 1'b1, 1'b1, PC_W'(32'hBAD));
        step("flush");
        check("flush.count", 64'(o_count),   64'd0);
        check("flush.valid", 64'(valid_out), 64'd0);
        drive(1'b1, 1'b0, 1'b0, PC_W'(32'h200));
        step("post_flush");
        check("post_flush.pc", 64'(o_pc), 64'h200);

        // Full plus pop: input stalls this cycle, freed slot taken on the next.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, PC_W'(32'h204 + 4 * i));
            step($sformatf("refill%0d", i));
        end
        drive(1'b1, 1'b1, 1'b0, PC_W'(32'h300));
        #1;
        check("fullpop.ready_in", 64'(ready_in), 64'd0);
        step("fullpop");
        check("fullpop.count", 64'(o_count), 64'd3);
        drive(1'b1, 1'b0, 1'b0, PC_W'(32'h300));
        step("fullpop_next");
        check("fullpop_next.count", 64'(o_count), 64'd4);

        // Asynchronous reset mid-cycle at count 2.
        drive(1'b0, 1'b1, 1'b0, '0);
        step("down0");
        step("down1");
        check("down.count", 64'(o_count), 64'd2);
        drive(1'b0, 1'b0, 1'b0, '0);
        #2 rst = 1'b1;
        #1;
        model_q.delete();
        check("arst.valid_out", 64'(valid_out), 64'd0);
        check("arst.count",     64'(o_count),   64'd0);
        check("arst.ready_in",  64'(ready_in),  64'd1);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, PC_W'(32'h600));
        step("arst_push");
        check("arst_push.pc", 64'(o_pc), 64'h600);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            valid_in         = 1'($urandom_range(0, 3) != 0);
            ready_out        = 1'($urandom_range(0, 2) != 0);
            i_flush          = 1'($urandom_range(0, 19) == 0);
            i_pc             = PC_W'($urandom);
            i_inst           = INST_W'($urandom);
            i_branch_predict = 1'($urandom);
            step($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_core_id_inst_queue
